booth_mac_ctrl: RTL and testbench
=================================

# booth_mac_ctrl

Sequencing and accumulation stage that sits directly in front of and behind `booth_multiplier`. It accepts signed 8-bit operand pairs over a valid/ready handshake and pulses the multiplier's `start`. It captures the 16-bit product exactly when the multiplier finishes, and accumulates products into a signed accumulator. A completed dot product, terminated by `in_last`, is presented on a valid/ready output.

## Interface
Parameters:
- `ACC_W`, 24: accumulator width in bits; must be ≥16.

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  block can accept a pair
- `in_a`  in  8  signed multiplicand
- `in_b`  in  8  signed multiplier
- `in_last`  in  1  pair is the final term of the current dot product
- `mul_start`  out  1  to `booth_multiplier.start`
- `mul_mc`  out  8  to `booth_multiplier.mc`
- `mul_mp`  out  8  to `booth_multiplier.mp`
- `mul_busy`  in  1  from `booth_multiplier.busy`
- `mul_prod`  in  16  from `booth_multiplier.prod` (signed)
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `out_acc`  out  `ACC_W`  signed dot-product result
- `out_ovf`  out  1  signed overflow occurred in this dot product
- `err`  out  1  sticky: `mul_busy` disagreed with the internal cycle count

## Operation
- The FSM has five states: IDLE → START → RUN → CAPTURE → (IDLE | DONE).
- IDLE: `in_ready`=1. On `in_valid & in_ready`, register `in_a`/`in_b` into `mul_mc`/`mul_mp`, register `in_last`, and go to START.
- START: `mul_start`=1 for exactly one cycle, with `mul_mc`/`mul_mp` stable. Then go to RUN and clear the 4-bit `cyc` counter.
- RUN: increment `cyc` each cycle. When `cyc`==7, go to CAPTURE.
- CAPTURE: sign-extend `mul_prod` to `ACC_W` and add it to `acc`.
  - Set `ovf` if the two operands have the same sign and the sum's sign differs. `ovf` is sticky for the dot product; `acc` wraps (no saturation).
  - If `mul_busy`=1 in this cycle, set `err` (sticky until `rst`).
  - If `last`, go to DONE; else go to IDLE.
- DONE: `out_valid`=1, with `out_acc`=`acc` and `out_ovf`=`ovf` held stable. On `out_ready`, clear `acc`/`ovf` and go to IDLE.
- The multiplier's 4-bit counter wraps and `busy` re-asserts 16 cycles after load. The block therefore samples the product only in CAPTURE and never uses `mul_busy` for control.
- `mul_busy` is X before the first `start`; it is ignored outside CAPTURE.
- The multiplier has no reset. After `rst`, the next START fully re-initialises it; no special handling is required.

## Timing
- Reset values: `in_ready`=0 during `rst` and 1 in the cycle after; `mul_start`=0; `mul_mc`=`mul_mp`=0; `out_valid`=0; `out_acc`=0; `out_ovf`=0; `err`=0; state=IDLE; `acc`=0.
- Input handshake in cycle T0 gives the following cycle-level sequence:
  - `mul_start`=1 in T1.
  - Multiplier shifts on the edges ending T2..T9; product is valid and `busy`=0 in T10.
  - CAPTURE is T10.
  - If `last`, `out_valid`=1 from T11.
- Throughput: one pair per 11 cycles when the output is not stalled. `in_ready`=0 in START/RUN/CAPTURE/DONE.
- `rst` mid-operation (any state): abort immediately, discard partial `acc`, and `mul_start`=0 next cycle. `err` clears only on `rst`.
- `out_ready` while `out_valid`=0 is ignored. `out_acc` must not change while `out_valid`=1 and `out_ready`=0.

## Structure
- Shared package `booth_pkg`: FSM state enum, `MUL_CYCLES`=8, `OP_W`=8, `PROD_W`=16.
- Natural sub-module: `mac_accumulator`, which holds `acc`/`ovf`, performs the sign-extended add with overflow detect, and provides a clear input. The FSM and handshakes stay in `booth_mac_ctrl`.
- The bench and top level instantiate `booth_multiplier` alongside this block; this block does not contain the multiplier.

## Test plan
- Single pair 3×5 with `in_last`=1, `out_ready`=1 → `out_valid` rises 11 cycles after the handshake with `out_acc`=15, `out_ovf`=0, `err`=0.
- Pairs (2,7), (−3,4 last) → `out_acc`=2; pair (−128,−128 last) → `out_acc`=16384; pair (−128,127 last) → `out_acc`=−16256.
- 512 pairs of (−128,−128), last on the 512th → `out_ovf`=1, `out_acc`=−8388608 (wrapped). The next dot product (1,1 last) → `out_acc`=1, `out_ovf`=0.
- `out_ready` held 0 for 20 cycles in DONE → `out_valid`, `out_acc` stable and `in_ready`=0 throughout. Release → accept occurs and `in_ready`=1 next cycle.
- `rst` asserted in RUN after a non-last pair (acc=15) → after `rst`, a pair (1,1 last) gives `out_acc`=1.
- Bench forces `mul_busy`=1 in CAPTURE → `err`=1 and stays 1 until `rst`; the accumulate result is unaffected.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier front/back-end: operand widths,
// multiplier latency and the MAC sequencer state encoding.
package booth_pkg;
    localparam int OP_W       = 8;
    localparam int PROD_W     = 16;
    localparam int MUL_CYCLES = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_CAPTURE,
        S_DONE
    } mac_state_e;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic            last;
    } op_req_t;
endpackage

// File: rtl/mac_accumulator.sv
// Signed wrapping accumulator with sticky overflow flag.
// The product is sign-extended to ACC_W before it is added.
module mac_accumulator
    import booth_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    add_en,
    input  logic [PROD_W-1:0]       prod,
    output logic signed [ACC_W-1:0] acc,
    output logic                    ovf
);
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic                    sum_ovf;

    assign prod_ext = ACC_W'($signed(prod));
    assign sum      = acc + prod_ext;
    // Overflow: both addends share a sign that the wrapped sum does not.
    assign sum_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

    always_ff @(posedge clk) begin
        if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (add_en) begin
            acc <= sum;
            ovf <= ovf | sum_ovf;
        end
    end
endmodule

// File: rtl/booth_mac_ctrl.sv
// Sequencer around booth_multiplier: accepts operand pairs, times the multiply
// with its own counter, accumulates products and presents each dot product.
module booth_mac_ctrl
    import booth_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_W-1:0]         in_a,
    input  logic [OP_W-1:0]         in_b,
    input  logic                    in_last,
    output logic                    mul_start,
    output logic [OP_W-1:0]         mul_mc,
    output logic [OP_W-1:0]         mul_mp,
    input  logic                    mul_busy,
    input  logic [PROD_W-1:0]       mul_prod,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_acc,
    output logic                    out_ovf,
    output logic                    err
);
    mac_state_e state, state_nx;
    op_req_t    op_q;
    logic [3:0] cyc;
    logic       acc_add;
    logic       acc_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op_q  <= '0;
            cyc   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && in_valid)
                op_q <= '{a: in_a, b: in_b, last: in_last};
            if (state == S_START)
                cyc <= '0;
            else if (state == S_RUN)
                cyc <= cyc + 4'd1;
            // busy is only meaningful in CAPTURE; elsewhere it may be X or wrapped.
            if (state == S_CAPTURE && mul_busy)
                err <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        acc_add  = 1'b0;
        acc_clr  = 1'b0;
        case (state)
            S_IDLE:    if (in_valid) state_nx = S_START;
            S_START:   state_nx = S_RUN;
            S_RUN:     if (cyc == 4'(MUL_CYCLES - 1)) state_nx = S_CAPTURE;
            S_CAPTURE: begin
                acc_add  = 1'b1;
                state_nx = op_q.last ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                if (out_ready) begin
                    acc_clr  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default:   state_nx = S_IDLE;
        endcase
    end

    mac_accumulator #(.ACC_W(ACC_W)) u_acc (
        .clk    (clk),
        .clr    (rst | acc_clr),
        .add_en (acc_add),
        .prod   (mul_prod),
        .acc    (out_acc),
        .ovf    (out_ovf)
    );

    assign in_ready  = (state == S_IDLE) && !rst;
    assign mul_start = (state == S_START);
    assign mul_mc    = op_q.a;
    assign mul_mp    = op_q.b;
    assign out_valid = (state == S_DONE);
endmodule

// File: tb/tb_booth_mac_ctrl.sv
// Directed bench for booth_mac_ctrl with a cycle-accurate behavioural
// stand-in for booth_multiplier (load on start, 8 shifts, then product).
module tb_booth_mac_ctrl;
    localparam int ACC_W = 24;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid, in_ready, in_last;
    logic [7:0]              in_a, in_b;
    logic                    mul_start, mul_busy;
    logic [7:0]              mul_mc, mul_mp;
    logic [15:0]             mul_prod;
    logic                    out_valid, out_ready, out_ovf, err;
    logic signed [ACC_W-1:0] out_acc;

    logic        m_busy = 1'b0;
    logic [3:0]  m_cnt = '0;
    logic [15:0] m_prod = '0;
    logic        force_busy = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_mac_ctrl #(.ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .mul_start (mul_start),
        .mul_mc    (mul_mc),
        .mul_mp    (mul_mp),
        .mul_busy  (mul_busy),
        .mul_prod  (mul_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf),
        .err       (err)
    );

    always @(posedge clk) begin
        if (mul_start) begin
            m_busy <= 1'b1;
            m_cnt  <= '0;
            m_prod <= 16'h5a5a;
        end else if (m_busy) begin
            m_cnt <= m_cnt + 4'd1;
            if (m_cnt == 4'd7) begin
                m_busy <= 1'b0;
                m_prod <= $signed({{8{mul_mc[7]}}, mul_mc}) * $signed({{8{mul_mp[7]}}, mul_mp});
            end
        end
    end
    assign mul_busy = m_busy | force_busy;
    assign mul_prod = m_prod;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Handshake one pair; returns at the negedge of the cycle after acceptance.
    task automatic send(input logic signed [7:0] a, input logic signed [7:0] b, input logic last);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("in_ready_timeout", 0, 1);
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait for out_valid, compare, and let out_ready (held 1) retire it.
    task automatic expect_result(input string tag, input int acc, input logic ovf);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk({tag, "_timeout"}, 0, 1);
        chk({tag, "_acc"}, out_acc, acc);
        chk({tag, "_ovf"}, 32'(out_ovf), 32'(ovf));
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_acc", out_acc, 0);
        chk("rst_mul_mc", 32'(mul_mc), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // 3x5 last: start in T1, out_valid 11 cycles after the handshake
        send(8'sd3, 8'sd5, 1'b1);
        chk("t1_mul_start", 32'(mul_start), 1);
        n = 1;
        @(negedge clk);
        n++;
        chk("t2_mul_start", 32'(mul_start), 0);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 11);
        chk("p1_acc", out_acc, 15);
        chk("p1_ovf", 32'(out_ovf), 0);
        chk("p1_err", 32'(err), 0);
        @(negedge clk);

        send(8'sd2, 8'sd7, 1'b0);
        send(-8'sd3, 8'sd4, 1'b1);
        expect_result("dot2", 2, 1'b0);
        send(-8'sd128, -8'sd128, 1'b1);
        expect_result("mm", 16384, 1'b0);
        send(-8'sd128, 8'sd127, 1'b1);
        expect_result("mp", -16256, 1'b0);

        for (int i = 0; i < 512; i++)
            send(-8'sd128, -8'sd128, i == 511);
        expect_result("wrap", -8388608, 1'b1);
        send(8'sd1, 8'sd1, 1'b1);
        expect_result("after_wrap", 1, 1'b0);

        // Output stall
        out_ready = 1'b0;
        send(8'sd3, 8'sd5, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_acc", out_acc, 15);
            chk("stall_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 1);
        chk("release_out_valid", 32'(out_valid), 0);

        // Reset in RUN after a non-last pair
        send(8'sd3, 8'sd5, 1'b0);
        n = 0;
        while (!(dut.acc_add) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("mid_acc", out_acc, 15);
        send(8'sd1, 8'sd1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 0);
        chk("abort_mul_start", 32'(mul_start), 0);
        chk("abort_acc", out_acc, 0);
        rst = 1'b0;
        @(negedge clk);
        send(8'sd1, 8'sd1, 1'b1);
        expect_result("post_abort", 1, 1'b0);

        // Forced busy during CAPTURE sets sticky err
        force_busy = 1'b1;
        send(8'sd2, 8'sd3, 1'b1);
        expect_result("busy", 6, 1'b0);
        force_busy = 1'b0;
        chk("err_set", 32'(err), 1);
        send(-8'sd1, 8'sd1, 1'b1);
        expect_result("busy_after", -1, 1'b0);
        chk("err_sticky", 32'(err), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("err_cleared", 32'(err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
